// File: rtl/counter_feeder.sv
// counter_feeder: splits a loaded total into a stream of bounded increment
// pulses so a downstream accumulating counter, starting at zero, rebuilds the
// exact total. The downstream side can stall emission, and an optional idle
// gap can be inserted after each pulse.
//
// state | meaning
// IDLE  | ready for a new total; a zero total completes here immediately
// SEND  | emitting min(remaining, MAX_AMT) each cycle unless held
// GAP   | idle spacing after a non-final pulse, counted down by gap_cnt
module counter_feeder #(
  parameter int TOT_W      = 8,
  parameter int AMT_W      = 4,
  parameter int MAX_AMT    = 15,
  parameter int GAP_CYCLES = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             io_load_valid,
  input  logic [TOT_W-1:0] io_load_total,
  output logic             io_load_ready,
  input  logic             io_hold,
  output logic             io_inc,
  output logic [AMT_W-1:0] io_amt,
  output logic             io_busy,
  output logic             io_done,
  output logic [TOT_W-1:0] io_sent
);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  localparam logic [TOT_W-1:0] MAX_T = TOT_W'(MAX_AMT);
  // Gap counter reloads to GAP_CYCLES-1 so that exactly GAP_CYCLES idle
  // cycles separate consecutive pulses.
  localparam logic [7:0] GAP_LOAD = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

  state_t           state_q, state_d;
  logic [TOT_W-1:0] remaining_q, remaining_d;
  logic [7:0]       gap_cnt_q, gap_cnt_d;
  logic [TOT_W-1:0] sent_q, sent_d;
  logic             done_q, done_d;

  logic [TOT_W-1:0] chunk;
  logic             last_pulse;

  // Chunk size for the current pulse; it never exceeds remaining.
  always_comb begin
    chunk      = (remaining_q < MAX_T) ? remaining_q : MAX_T;
    last_pulse = (chunk == remaining_q);
  end

  // Next-state, datapath updates and pulse outputs.
  always_comb begin
    state_d       = state_q;
    remaining_d   = remaining_q;
    gap_cnt_d     = gap_cnt_q;
    sent_d        = sent_q;
    done_d        = 1'b0;
    io_load_ready = 1'b0;
    io_inc        = 1'b0;
    io_amt        = '0;
    case (state_q)
      IDLE: begin
        io_load_ready = 1'b1;
        if (io_load_valid) begin
          remaining_d = io_load_total;
          sent_d      = '0;
          if (io_load_total != '0) state_d = SEND;
          else                     done_d  = 1'b1;
        end
      end
      SEND: begin
        if (!io_hold) begin
          io_inc      = 1'b1;
          io_amt      = AMT_W'(chunk);
          remaining_d = remaining_q - chunk;
          sent_d      = sent_q + chunk;
          if (last_pulse) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else if (GAP_CYCLES > 0) begin
            state_d   = GAP;
            gap_cnt_d = GAP_LOAD;
          end
        end
      end
      GAP: begin
        // The gap runs regardless of io_hold.
        if (gap_cnt_q == 8'd0) state_d   = SEND;
        else                   gap_cnt_d = gap_cnt_q - 8'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      gap_cnt_q   <= '0;
      sent_q      <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      gap_cnt_q   <= gap_cnt_d;
      sent_q      <= sent_d;
      done_q      <= done_d;
    end
  end

  assign io_busy = (state_q != IDLE);
  assign io_done = done_q;
  assign io_sent = sent_q;

endmodule

// File: tb/tb_counter_feeder.sv
// Bench for counter_feeder: a GAP_CYCLES=0 instance checked through a pulse
// scoreboard plus an accumulating counter model, and a GAP_CYCLES=2 instance
// checked cycle by cycle.
module tb_counter_feeder;

  logic       clk = 1'b0;
  logic       reset;
  logic       load_valid, hold;
  logic [7:0] load_total;
  logic       load_ready, inc, busy, done;
  logic [3:0] amt;
  logic [7:0] sent;

  logic       g_valid, g_hold;
  logic [7:0] g_total;
  logic       g_ready, g_inc, g_busy, g_done;
  logic [3:0] g_amt;
  logic [7:0] g_sent;

  int tests = 0;
  int fails = 0;

  logic [3:0] exp_q[$];
  logic [7:0] tot_q[$];
  int         acc = 0;
  logic [3:0] sb_e;
  logic [7:0] sb_t;

  always #5 clk = ~clk;

  counter_feeder #(.TOT_W(8), .AMT_W(4), .MAX_AMT(15), .GAP_CYCLES(0)) dut (
    .clk(clk), .reset(reset),
    .io_load_valid(load_valid), .io_load_total(load_total), .io_load_ready(load_ready),
    .io_hold(hold), .io_inc(inc), .io_amt(amt),
    .io_busy(busy), .io_done(done), .io_sent(sent)
  );

  counter_feeder #(.TOT_W(8), .AMT_W(4), .MAX_AMT(15), .GAP_CYCLES(2)) dut_g (
    .clk(clk), .reset(reset),
    .io_load_valid(g_valid), .io_load_total(g_total), .io_load_ready(g_ready),
    .io_hold(g_hold), .io_inc(g_inc), .io_amt(g_amt),
    .io_busy(g_busy), .io_done(g_done), .io_sent(g_sent)
  );

  // Scoreboard and downstream counter model for the main instance.
  always @(negedge clk) begin
    if (inc) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL sb_amt: unexpected pulse amt=%0d", amt);
      end else begin
        sb_e = exp_q.pop_front();
        if (amt !== sb_e) begin
          fails++;
          $display("FAIL sb_amt: got %0d expected %0d", amt, sb_e);
        end
      end
      acc = acc + int'(amt);
    end else begin
      tests++;
      if (amt !== 4'd0) begin
        fails++;
        $display("FAIL amt_idle: got %0d expected 0", amt);
      end
    end
    if (done) begin
      tests++;
      if (tot_q.size() == 0) begin
        fails++;
        $display("FAIL sb_done: unexpected done, count=%0d", acc);
      end else begin
        sb_t = tot_q.pop_front();
        if (acc !== int'(sb_t)) begin
          fails++;
          $display("FAIL recon: count %0d expected %0d", acc, sb_t);
        end
      end
      acc = 0;
    end
  end

  task automatic push_exp(input int t);
    int r;
    r = t;
    tot_q.push_back(8'(t));
    while (r > 0) begin
      if (r > 15) begin exp_q.push_back(4'd15); r -= 15; end
      else begin exp_q.push_back(4'(r)); r = 0; end
    end
  endtask

  // Offers t in cycle N; returns 1ns into cycle N+1.
  task automatic do_load(input int t);
    @(posedge clk); #1;
    load_valid = 1'b1;
    load_total = 8'(t);
    push_exp(t);
    @(posedge clk); #1;
    load_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++;
    if (load_ready !== 1'b1 || inc !== 1'b0 || amt !== 4'd0 || busy !== 1'b0 ||
        done !== 1'b0 || sent !== 8'd0) begin
      fails++;
      $display("FAIL reset_main: ready=%b inc=%b amt=%0d busy=%b done=%b sent=%0d required 1 0 0 0 0 0",
               load_ready, inc, amt, busy, done, sent);
    end
    tests++;
    if (g_ready !== 1'b1 || g_inc !== 1'b0 || g_busy !== 1'b0 || g_done !== 1'b0 || g_sent !== 8'd0) begin
      fails++;
      $display("FAIL reset_gap: ready=%b inc=%b busy=%b done=%b sent=%0d", g_ready, g_inc, g_busy, g_done, g_sent);
    end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_basic;
    do_load(40);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      tests++;
      if (inc !== (k <= 3) || done !== (k == 4)) begin
        fails++;
        $display("FAIL basic_timing: N+%0d inc=%b done=%b required %b %b", k, inc, done, k <= 3, k == 4);
      end
    end
    tests++;
    if (sent !== 8'd40) begin
      fails++;
      $display("FAIL basic_sent: got %0d expected 40", sent);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_zero;
    do_load(0);
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      tests++;
      if (inc !== 1'b0 || busy !== 1'b0 || done !== (k == 1)) begin
        fails++;
        $display("FAIL zero_total: N+%0d inc=%b busy=%b done=%b required 0 0 %b", k, inc, busy, done, k == 1);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_hold;
    hold = 1'b1;
    do_load(30);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      tests++;
      if (inc !== 1'b0 || amt !== 4'd0 || busy !== 1'b1) begin
        fails++;
        $display("FAIL hold_stall: N+%0d inc=%b amt=%0d busy=%b required 0 0 1", k, inc, amt, busy);
      end
    end
    @(posedge clk); #1;
    hold = 1'b0;
    for (int k = 4; k <= 6; k++) begin
      @(negedge clk);
      tests++;
      if (inc !== (k <= 5) || done !== (k == 6)) begin
        fails++;
        $display("FAIL hold_resume: N+%0d inc=%b done=%b required %b %b", k, inc, done, k <= 5, k == 6);
      end
      if (k < 6) begin @(posedge clk); #1; end
    end
    tests++;
    if (sent !== 8'd30) begin
      fails++;
      $display("FAIL hold_sent: got %0d expected 30", sent);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_gap;
    logic       e_inc [1:8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [3:0] e_amt [1:8] = '{4'd15, 4'd0, 4'd0, 4'd15, 4'd0, 4'd0, 4'd1, 4'd0};
    @(posedge clk); #1;
    g_valid = 1'b1;
    g_total = 8'd31;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      g_valid = (k == 2);
      g_total = 8'd99;
      @(negedge clk);
      tests++;
      if (g_inc !== e_inc[k] || g_amt !== e_amt[k] || g_done !== (k == 8) || g_busy !== (k < 8)) begin
        fails++;
        $display("FAIL gap_seq: N+%0d inc=%b amt=%0d done=%b busy=%b required %b %0d %b %b",
                 k, g_inc, g_amt, g_done, g_busy, e_inc[k], e_amt[k], k == 8, k < 8);
      end
      if (k == 2) begin
        tests++;
        if (g_ready !== 1'b0) begin
          fails++;
          $display("FAIL gap_busy_load: ready=%b required 0", g_ready);
        end
      end
    end
    tests++;
    if (g_sent !== 8'd31 || g_ready !== 1'b1) begin
      fails++;
      $display("FAIL gap_end: sent=%0d ready=%b required 31 1", g_sent, g_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    do_load(255);
    for (int k = 1; k <= 18; k++) begin
      if (k == 18) begin
        load_valid = 1'b1;
        load_total = 8'd7;
        push_exp(7);
      end
      @(negedge clk);
      tests++;
      if (inc !== (k <= 17) || done !== (k == 18)) begin
        fails++;
        $display("FAIL max_timing: N+%0d inc=%b done=%b required %b %b", k, inc, done, k <= 17, k == 18);
      end
      if (k == 18) begin
        tests++;
        if (load_ready !== 1'b1 || sent !== 8'd255) begin
          fails++;
          $display("FAIL done_ready: ready=%b sent=%0d required 1 255", load_ready, sent);
        end
      end
      @(posedge clk); #1;
    end
    load_valid = 1'b0;
    for (int k = 19; k <= 20; k++) begin
      @(negedge clk);
      tests++;
      if (inc !== (k == 19) || done !== (k == 20)) begin
        fails++;
        $display("FAIL b2b_timing: N+%0d inc=%b done=%b required %b %b", k, inc, done, k == 19, k == 20);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid;
    do_load(40);
    @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    tests++;
    if (inc !== 1'b1) begin
      fails++;
      $display("FAIL rmid_pre: N+2 inc=%b required 1", inc);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    for (int k = 3; k <= 6; k++) begin
      @(negedge clk);
      tests++;
      if (inc !== 1'b0 || sent !== 8'd0 || done !== 1'b0 || load_ready !== 1'b1 || busy !== 1'b0) begin
        fails++;
        $display("FAIL rmid: N+%0d inc=%b sent=%0d done=%b ready=%b busy=%b required 0 0 0 1 0",
                 k, inc, sent, done, load_ready, busy);
      end
      @(posedge clk); #1;
    end
    exp_q.delete();
    tot_q.delete();
    acc = 0;
  endtask

  task automatic test_random;
    bit got;
    for (int n = 0; n < 20; n++) begin
      hold = 1'b0;
      do_load(int'($urandom_range(0, 255)));
      got = 1'b0;
      for (int c = 0; c < 1000 && !got; c++) begin
        @(negedge clk);
        if (done) got = 1'b1;
        @(posedge clk); #1;
        hold = $urandom_range(0, 1) == 1;
      end
      if (!got) begin
        tests++;
        fails++;
        $display("FAIL random_timeout: no done within budget on transfer %0d", n);
      end
    end
    hold = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    load_valid = 1'b0; load_total = 8'd0; hold = 1'b0;
    g_valid = 1'b0; g_total = 8'd0; g_hold = 1'b0;
    test_reset;
    test_basic;
    test_zero;
    test_hold;
    test_gap;
    test_back_to_back;
    test_reset_mid;
    test_random;
    repeat (2) @(posedge clk);
    tests++;
    if (exp_q.size() != 0 || tot_q.size() != 0) begin
      fails++;
      $display("FAIL sb_leftover: %0d pulses %0d totals still expected", exp_q.size(), tot_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
